sram_ctrl: RTL

Memory-stage controller that sequences the off-chip 16-bit SRAM on behalf of the pipeline's 32-bit load/store path. It accepts a single-cycle read or write request from the EXE/MEM register outputs and runs it as two half-word SRAM phases. While an access is in progress it holds `ready` low; the pipeline drives `freeze` from `~ready` on every stage register. It sits between the EXE register and the MEM register, replacing the single-cycle data memory.

---
 rtl/arm_pkg.sv | 18 +
 rtl/sram_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
package arm_pkg;

  // Access sequencing: one idle slot, two half-word phases, one completion slot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_t;

  // Width of the off-chip SRAM data bus.
  localparam int SRAM_DATA_W = 16;

  // Byte address that maps onto data memory word 0.
  localparam int DEFAULT_BASE = 1024;

endpackage

// File: rtl/sram_ctrl.sv
// Sequences one 32-bit load/store as two 16-bit SRAM phases and stalls the
// pipeline through `ready` until the access reaches DONE.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int PHASE  = 2,
  parameter int BASE   = DEFAULT_BASE,
  parameter int ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  localparam int          CNT_W    = (PHASE > 1) ? $clog2(PHASE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PHASE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0] BASE_U   = 32'(BASE);

  sram_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             op_wr;

  logic [31:0]       offset;
  logic [ADDR_W-2:0] word;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;
  logic              unused_bits;

  // Byte offset into data memory; the subtraction wraps modulo 2^32 and the
  // byte-lane bits are dropped because accesses are always whole words.
  assign offset      = address - BASE_U;
  assign word        = offset[ADDR_W:2];
  assign addr_lo     = {word, 1'b0};
  assign addr_hi     = {word, 1'b1};
  assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  // Stall the pipeline while any request is outstanding, releasing it only in
  // the completion cycle so the MEM register captures rdata at that edge.
  assign ready = !((rd_en || wr_en) && (state != DONE));

  // FSM, phase counter and registered SRAM pins; address/data are re-read every
  // cycle rather than latched, since the pipeline is frozen while ready is low.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch;
    // every state register is a plain flop and uses non-blocking assignment.
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            state       <= LO;
            op_wr       <= wr_en;
            cnt         <= CNT_LOAD;
            sram_addr   <= addr_lo;
            sram_we_n   <= !wr_en;
            sram_dq_oe  <= wr_en;
            sram_dq_out <= wr_en ? wdata[15:0] : '0;
          end
        end

        LO: begin
          if (cnt == '0) begin
            state       <= HI;
            cnt         <= CNT_LOAD;
            sram_addr   <= addr_hi;
            sram_we_n   <= !op_wr;
            sram_dq_out <= op_wr ? wdata[31:16] : '0;
            if (!op_wr) rdata[15:0] <= sram_dq_in;
          end else begin
            cnt         <= cnt - CNT_ONE;
            sram_addr   <= addr_lo;
            // Strobe rises on the last cycle so address/data straddle its edge.
            sram_we_n   <= !op_wr || (cnt == CNT_ONE);
            sram_dq_out <= op_wr ? wdata[15:0] : '0;
          end
        end

        HI: begin
          if (cnt == '0) begin
            state       <= DONE;
            cnt         <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= '0;
            if (!op_wr) rdata[31:16] <= sram_dq_in;
          end else begin
            cnt         <= cnt - CNT_ONE;
            sram_addr   <= addr_hi;
            sram_we_n   <= !op_wr || (cnt == CNT_ONE);
            sram_dq_out <= op_wr ? wdata[31:16] : '0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
